// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, control
// levels and the fetch FSM state encoding.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_DATA_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  typedef enum logic [1:0] {
    IF_RESET = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory req/ack channel plus the if/id
// hand-off to decode (including decode's stall back-pressure).
interface if_stage_if;
  import if_stage_pkg::*;

  logic                     imem_ce_o;
  logic                     imem_req_o;
  logic [INST_ADDR_BUS-1:0] imem_addr_o;
  logic                     imem_ack_i;
  logic [INST_DATA_BUS-1:0] imem_data_i;

  logic [INST_ADDR_BUS-1:0] id_pc_o;
  logic [INST_DATA_BUS-1:0] id_inst_o;
  logic                     id_valid_o;
  logic                     stall_i;

  modport master (
    output imem_ce_o, imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_data_i,
    output id_pc_o, id_inst_o, id_valid_o,
    input  stall_i
  );

  modport slave (
    input  imem_ce_o, imem_req_o, imem_addr_o,
    output imem_ack_i, imem_data_i,
    input  id_pc_o, id_inst_o, id_valid_o,
    output stall_i
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: restarts at RESET_PC and advances by PC_STEP (modulo 2^32)
// whenever the fetch stage hands an instruction to decode.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance_i,
  output logic [INST_ADDR_BUS-1:0] pc_o
);

  logic [INST_ADDR_BUS-1:0] pc_q;
  logic [INST_ADDR_BUS-1:0] pc_d;

  // Next pc: wraps silently past the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      pc_d = pc_q + INST_ADDR_BUS'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end
  end

  // Pc register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one req/ack fetch per instruction, parks an
// acked word in a hold buffer while decode stalls, and fills gaps with NOPs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned              PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  if_state_e                state_q, state_d;
  logic [INST_ADDR_BUS-1:0] pc_s;
  logic                     advance_s;
  logic [INST_DATA_BUS-1:0] hold_buf_q, hold_buf_d;
  logic [INST_ADDR_BUS-1:0] id_pc_q, id_pc_d;
  logic [INST_DATA_BUS-1:0] id_inst_q, id_inst_d;
  logic                     id_valid_q, id_valid_d;
  logic                     ce_s, req_s;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance_s),
    .pc_o      (pc_s)
  );

  // Next-state, if/id update and memory-control decode.
  always_comb begin
    state_d    = state_q;
    hold_buf_d = hold_buf_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    advance_s  = 1'b0;
    ce_s       = CHIP_DISABLE;
    req_s      = 1'b0;
    case (state_q)
      IF_RESET: begin
        state_d = IF_FETCH;
      end
      IF_FETCH: begin
        ce_s  = CHIP_ENABLE;
        req_s = 1'b1;
        if (bus.imem_ack_i) begin
          if (bus.stall_i == NO_STOP) begin
            id_pc_d    = pc_s;
            id_inst_d  = bus.imem_data_i;
            id_valid_d = 1'b1;
            advance_s  = 1'b1;
          end else begin
            hold_buf_d = bus.imem_data_i;
            state_d    = IF_HOLD;
          end
        end else if (bus.stall_i == NO_STOP) begin
          // No word yet: present a bubble tagged with the pending pc.
          id_pc_d    = pc_s;
          id_inst_d  = ZERO_WORD;
          id_valid_d = 1'b0;
        end else begin
          state_d = IF_FETCH;
        end
      end
      IF_HOLD: begin
        ce_s = CHIP_ENABLE;
        if (bus.stall_i == NO_STOP) begin
          id_pc_d    = pc_s;
          id_inst_d  = hold_buf_q;
          id_valid_d = 1'b1;
          advance_s  = 1'b1;
          state_d    = IF_FETCH;
        end else begin
          state_d = IF_HOLD;
        end
      end
      default: begin
        state_d = IF_RESET;
      end
    endcase
    // Reset abandons any outstanding request in the same cycle.
    if (rst == RST_ENABLE) begin
      ce_s      = CHIP_DISABLE;
      req_s     = 1'b0;
      advance_s = 1'b0;
    end else begin
      advance_s = advance_s;
    end
  end

  // State, hold buffer and if/id output registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= IF_RESET;
      hold_buf_q <= ZERO_WORD;
      id_pc_q    <= ZERO_WORD;
      id_inst_q  <= ZERO_WORD;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_buf_q <= hold_buf_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.imem_ce_o   = ce_s;
  assign bus.imem_req_o  = req_s;
  assign bus.imem_addr_o = pc_s;
  assign bus.id_pc_o     = id_pc_q;
  assign bus.id_inst_o   = id_inst_q;
  assign bus.id_valid_o  = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait fetch, delayed ack, stall/hold,
// reset mid-request and in HOLD, stray acks, and pc wrap-around.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ack;
  logic        ovr_en;
  logic [31:0] ovr_data;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Memory model: data = addr ^ A5A5_0000 unless a specific word is forced.
  assign bus.imem_ack_i  = ack;
  assign bus.imem_data_i = ovr_en ? ovr_data : (bus.imem_addr_o ^ 32'hA5A5_0000);
  assign bus.stall_i     = stall;
  assign bus2.imem_ack_i  = 1'b1;
  assign bus2.imem_data_i = bus2.imem_addr_o ^ 32'hA5A5_0000;
  assign bus2.stall_i     = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic valid);
    chk({tag, ".pc"}, bus.id_pc_o, pc);
    chk({tag, ".inst"}, bus.id_inst_o, inst);
    chk({tag, ".valid"}, {31'd0, bus.id_valid_o}, {31'd0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ack = 1'b1; ovr_en = 1'b0; ovr_data = 32'h0000_0000;
    #1;
    chk("req_in_rst", {31'd0, bus.imem_req_o}, 32'd0);
    chk("ce_in_rst", {31'd0, bus.imem_ce_o}, 32'd0);
    step(); step();
    chk_id("reset", 32'h0, 32'h0, 1'b0);

    // RESET cycle (stray ack present) then zero-wait streaming.
    rst = 1'b0;
    chk("reset_cycle_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("reset_cycle_ce", {31'd0, bus.imem_ce_o}, 32'd0);
    step();
    chk_id("after_reset_cycle", 32'h0, 32'h0, 1'b0);
    chk("fetch_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("fetch_addr0", bus.imem_addr_o, 32'h0);
    step();
    chk_id("zw0", 32'h0, 32'hA5A5_0000, 1'b1);
    step();
    chk_id("zw4", 32'h4, 32'hA5A5_0004, 1'b1);
    chk("addr8", bus.imem_addr_o, 32'h8);

    // Ack at pc=8 delayed two cycles.
    ack = 1'b0;
    step();
    chk_id("bubble1", 32'h8, 32'h0, 1'b0);
    chk("addr_held1", bus.imem_addr_o, 32'h8);
    chk("req_held1", {31'd0, bus.imem_req_o}, 32'd1);
    step();
    chk_id("bubble2", 32'h8, 32'h0, 1'b0);
    chk("addr_held2", bus.imem_addr_o, 32'h8);
    ack = 1'b1;
    step();
    chk_id("late8", 32'h8, 32'hA5A5_0008, 1'b1);

    // Stall together with ack of pc=12; ack stays high (stray in HOLD).
    ovr_en = 1'b1; ovr_data = 32'h3421_0001; stall = 1'b1;
    step();
    chk_id("hold1", 32'h8, 32'hA5A5_0008, 1'b1);
    chk("hold_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("hold_ce", {31'd0, bus.imem_ce_o}, 32'd1);
    chk("hold_addr", bus.imem_addr_o, 32'hC);
    ovr_data = 32'hDEAD_BEEF;
    step();
    chk_id("hold2", 32'h8, 32'hA5A5_0008, 1'b1);
    step();
    chk_id("hold3", 32'h8, 32'hA5A5_0008, 1'b1);
    chk("hold3_addr", bus.imem_addr_o, 32'hC);
    stall = 1'b0; ovr_en = 1'b0;
    step();
    chk_id("release12", 32'hC, 32'h3421_0001, 1'b1);
    chk("next_addr16", bus.imem_addr_o, 32'h10);
    chk("next_req", {31'd0, bus.imem_req_o}, 32'd1);
    step();
    chk_id("after16", 32'h10, 32'hA5A5_0010, 1'b1);

    // Reset while in HOLD.
    stall = 1'b1;
    step();
    chk("hold_again_req", {31'd0, bus.imem_req_o}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_hold_ce", {31'd0, bus.imem_ce_o}, 32'd0);
    step();
    chk_id("rst_in_hold", 32'h0, 32'h0, 1'b0);
    chk("rst_in_hold_addr", bus.imem_addr_o, 32'h0);
    rst = 1'b0;
    chk("rst_hold_reset_req", {31'd0, bus.imem_req_o}, 32'd0);
    step();
    chk_id("stall_ignored_in_reset", 32'h0, 32'h0, 1'b0);
    chk("resume_req", {31'd0, bus.imem_req_o}, 32'd1);
    stall = 1'b0;
    step();
    chk_id("resume0", 32'h0, 32'hA5A5_0000, 1'b1);

    // Reset while a request is pending.
    ack = 1'b0;
    step();
    chk_id("pend_bubble", 32'h4, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_pend_req", {31'd0, bus.imem_req_o}, 32'd0);
    step();
    chk_id("rst_pend", 32'h0, 32'h0, 1'b0);
    rst = 1'b0; ack = 1'b1;
    chk("rst_pend_reset_req", {31'd0, bus.imem_req_o}, 32'd0);
    step();
    chk_id("rst_pend_stray_ack", 32'h0, 32'h0, 1'b0);
    chk("rst_pend_addr", bus.imem_addr_o, 32'h0);
    step();
    chk_id("rst_pend_resume", 32'h0, 32'hA5A5_0000, 1'b1);

    // Wrap-around instance: restart both from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("wrap_addr0", bus2.imem_addr_o, 32'hFFFF_FFF8);
    chk("wrap_idpc_reset", bus2.id_pc_o, 32'h0);
    step();
    chk("wrap_pc0", bus2.id_pc_o, 32'hFFFF_FFF8);
    chk("wrap_inst0", bus2.id_inst_o, 32'h5A5A_FFF8);
    step();
    chk("wrap_pc1", bus2.id_pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst1", bus2.id_inst_o, 32'h5A5A_FFFC);
    step();
    chk("wrap_pc2", bus2.id_pc_o, 32'h0000_0000);
    chk("wrap_inst2", bus2.id_inst_o, 32'hA5A5_0000);
    chk("wrap_valid2", {31'd0, bus2.id_valid_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
